// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg
//   Shared definitions for the gate truth-table sweep controller.
//   - tt_state_e : sweep FSM state encoding (IDLE, DRIVE, DONE)
//   - N_IN_MAX   : largest supported number of gate inputs
package tt_sweep_pkg;

  localparam int N_IN_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

endpackage

// File: rtl/tt_first_mismatch.sv
// tt_first_mismatch
//   Combinational lowest-set-bit encoder used to locate the first
//   mismatching truth-table entry.
//   Ports:
//     vec  in  P     mismatch vector (measured ^ expected)
//     idx  out N_IN  index of the lowest set bit, 0 when vec == 0
//     any  out 1     at least one bit of vec is set
module tt_first_mismatch
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 2,
  localparam int P   = 1 << N_IN
) (
  input  logic [P-1:0]    vec,
  output logic [N_IN-1:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = P - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = N_IN'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_tt_sweep.sv
// gate_tt_sweep
//   Sweeps a single-output gate through all 2**N_IN input patterns, holds
//   each pattern SETTLE cycles, samples the gate output into a shadow table
//   and, on completion, publishes the measured table with a pass flag and
//   the lowest mismatching pattern index.
//
//   Optional feature macro: TT_SWEEP_ABORT_EN (adds the abort input).
//
//   Ports:
//     clk       in   1     rising-edge clock
//     rst_n     in   1     asynchronous active-low reset
//     start     in   1     sweep request, accepted only in IDLE
//     expected  in   P     expected table, captured when start is accepted
//     abort     in   1     (TT_SWEEP_ABORT_EN only) cancel sweep while in DRIVE
//     gate_in   out  N_IN  pattern driven to the gate under test
//     gate_out  in   1     gate result
//     busy      out  1     high while driving patterns
//     done      out  1     one-cycle pulse at sweep completion
//     pass      out  1     measured table equals expected
//     truth     out  P     measured table
//     fail_idx  out  N_IN  lowest mismatching pattern, 0 when pass
//
//   State | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start, gate_in parked at 0
//   DRIVE | gate_in = idx, settle counter runs, sample at SETTLE-1
//   DONE  | single-cycle done pulse, results already registered
module gate_tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  localparam int P     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [P-1:0]    expected,
`ifdef TT_SWEEP_ABORT_EN
  input  logic            abort,
`endif
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [P-1:0]    truth,
  output logic [N_IN-1:0] fail_idx
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(P - 1);

  if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("gate_tt_sweep: N_IN out of range");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("gate_tt_sweep: SETTLE must be at least 1");
  end

  tt_state_e       state, state_nxt;
  logic [P-1:0]    exp_q;
  logic [P-1:0]    shadow;
  logic [P-1:0]    shadow_fin;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [N_IN-1:0] mis_idx;
  logic            mis_any;
  logic            sample;
  logic            last;
  logic            abort_hit;

  assign sample = (state == DRIVE) && (cnt == CNT_LAST);
  assign last   = sample && (idx == IDX_LAST);

`ifdef TT_SWEEP_ABORT_EN
  assign abort_hit = (state == DRIVE) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Shadow table with the current sample merged in, so the final pattern is
  // included in the result published on the edge that enters DONE.
  always_comb begin
    shadow_fin      = shadow;
    shadow_fin[idx] = gate_out;
  end

  tt_first_mismatch #(.N_IN(N_IN)) u_first_mismatch (
    .vec (shadow_fin ^ exp_q),
    .idx (mis_idx),
    .any (mis_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE: begin
        if (abort_hit)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate_in = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      DRIVE: begin
        gate_in = idx;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= '0;
      shadow   <= '0;
      idx      <= '0;
      cnt      <= '0;
      pass     <= 1'b0;
      truth    <= '0;
      fail_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q  <= expected;
            shadow <= '0;
            idx    <= '0;
            cnt    <= '0;
          end
        end
        DRIVE: begin
          if (!abort_hit) begin
            if (sample) begin
              shadow <= shadow_fin;
              if (last) begin
                truth    <= shadow_fin;
                pass     <= ~mis_any;
                fail_idx <= mis_any ? mis_idx : '0;
              end else begin
                idx <= idx + 1'b1;
                cnt <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sweep.sv
// tb_gate_tt_sweep
//   Scoreboard bench for gate_tt_sweep (default parameters N_IN=2, SETTLE=2).
//   Stimulus pushes the expected result of each sweep; a monitor pops and
//   compares whenever done is seen. A behavioural gate (OR/AND/XOR) drives
//   gate_out from gate_in. Abort checks compile only with TT_SWEEP_ABORT_EN.
module tb_gate_tt_sweep;

  localparam int N_IN   = 2;
  localparam int SETTLE = 2;
  localparam int P      = 4;
  // Sweep period with start held: P*SETTLE DRIVE cycles, one DONE, one IDLE.
  localparam int PERIOD = P * SETTLE + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [P-1:0]    expected = '0;
  logic [N_IN-1:0] gate_in;
  logic            gate_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [P-1:0]    truth;
  logic [N_IN-1:0] fail_idx;
`ifdef TT_SWEEP_ABORT_EN
  logic            abort = 1'b0;
`endif

  int gate_kind = 0;  // 0 = OR, 1 = AND, 2 = XOR

  typedef struct {
    logic [P-1:0]    truth;
    logic            pass;
    logic [N_IN-1:0] fidx;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  gate_tt_sweep #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
`ifdef TT_SWEEP_ABORT_EN
    .abort    (abort),
`endif
    .gate_in  (gate_in),
    .gate_out (gate_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .truth    (truth),
    .fail_idx (fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // gate_in[1] = a, gate_in[0] = b
  always_comb begin
    case (gate_kind)
      0:       gate_out = gate_in[1] | gate_in[0];
      1:       gate_out = gate_in[1] & gate_in[0];
      default: gate_out = gate_in[1] ^ gate_in[0];
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        check("sb_truth", truth, e.truth);
        check("sb_pass", pass, e.pass);
        check("sb_fail_idx", fail_idx, e.fidx);
      end
    end
  end

  task automatic issue(input int kind, input logic [P-1:0] tab,
                       input logic [P-1:0] tt, input logic ps, input logic [N_IN-1:0] fi);
    @(negedge clk);
    gate_kind = kind;
    expected  = tab;
    start     = 1'b1;
    sb.push_back(exp_t'{tt, ps, fi});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, done_cnt >= target, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gate_in"}, gate_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_truth"}, truth, 0);
    check({tag, "_fail_idx"}, fail_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nd;

    // Reset state
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // OR sweep with gate_in / busy / done trace
    @(negedge clk);
    gate_kind = 0;
    expected  = 4'b1110;
    start     = 1'b1;
    sb.push_back(exp_t'{4'b1110, 1'b1, 2'd0});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check("trace_gate_in", gate_in, (c - 1) / 2);
      check("trace_busy", busy, 1);
      check("trace_no_done", done, 0);
      if (c == 4) check("truth_hidden_mid_sweep", truth, 0);
    end
    @(negedge clk);
    #1;
    check("done_cycle_done", done, 1);
    check("done_cycle_gate_in", gate_in, 0);
    check("done_cycle_busy", busy, 0);
    @(negedge clk);
    #1;
    check("idle_gate_in", gate_in, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("or_done_count", done_cnt, 1);

    // AND gate against the OR table: first mismatch is pattern 1
    base = done_cnt;
    issue(1, 4'b1110, 4'b1000, 1'b0, 2'd1);
    wait_done(base + 1, "and_done_seen");

    // XOR against OR table; expected changes after capture must not matter
    base = done_cnt;
    @(negedge clk);
    gate_kind = 2;
    expected  = 4'b1110;
    start     = 1'b1;
    sb.push_back(exp_t'{4'b0110, 1'b0, 2'd3});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    expected = 4'b0110;
    #1;
    check("xor_truth_held_mid_sweep", truth, 4'b1000);
    wait_done(base + 1, "xor_done_seen");

    // start re-pulsed at cycles 3 and 8 of a sweep: one done only
    base = done_cnt;
    @(negedge clk);
    gate_kind = 0;
    expected  = 4'b1110;
    start     = 1'b1;
    sb.push_back(exp_t'{4'b1110, 1'b1, 2'd0});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 8);
    end
    repeat (20) @(negedge clk);
    #1;
    check("repulse_single_done", done_cnt - base, 1);
    check("repulse_idle_busy", busy, 0);

    // start held high: back-to-back sweeps
    base = done_cnt;
    nd   = done_cyc.size();
    @(negedge clk);
    gate_kind = 0;
    expected  = 4'b1110;
    start     = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(exp_t'{4'b1110, 1'b1, 2'd0});
    wait_done(base + 2, "held_second_done");
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 3, "held_third_done");
    if (done_cyc.size() >= nd + 3) begin
      check("held_spacing_1", done_cyc[nd + 1] - done_cyc[nd], PERIOD);
      check("held_spacing_2", done_cyc[nd + 2] - done_cyc[nd + 1], PERIOD);
    end

    // Asynchronous reset mid-sweep (outputs currently truth=1110, pass=1)
    @(negedge clk);
    gate_kind = 0;
    expected  = 4'b1110;
    start     = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    issue(1, 4'b1000, 4'b1000, 1'b1, 2'd0);
    wait_done(base + 1, "post_reset_done");

`ifdef TT_SWEEP_ABORT_EN
    // Abort after a passing OR sweep keeps the previous results
    base = done_cnt;
    issue(0, 4'b1110, 4'b1110, 1'b1, 2'd0);
    wait_done(base + 1, "pre_abort_done");
    base = done_cnt;
    @(negedge clk);
    gate_kind = 1;
    expected  = 4'b1110;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_gate_in", gate_in, 0);
    repeat (15) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, base);
    check("abort_truth_kept", truth, 4'b1110);
    check("abort_pass_kept", pass, 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
